// File: rtl/mem_stage_ls_if.sv
// EX/MEM-to-MEM/WB signal bundle for mem_stage_ls.
// The master side is the pipeline that feeds the stage; the slave side is the stage.
interface mem_stage_ls_if #(
  parameter int XLEN = 32
);
  logic            RegWriteM;
  logic            MemWriteM;
  logic            MemReadM;
  logic [1:0]      ResultSrcM;
  logic [2:0]      Funct3M;
  logic [4:0]      RD_M;
  logic [XLEN-1:0] PCPlus4M;
  logic [XLEN-1:0] WriteDataM;
  logic [XLEN-1:0] ALU_ResultM;
  logic            FlushW;
  logic            StallM;
  logic            MisalignM;
  logic            RegWriteW;
  logic [1:0]      ResultSrcW;
  logic [4:0]      RD_W;
  logic [XLEN-1:0] PCPlus4W;
  logic [XLEN-1:0] ALU_ResultW;
  logic [XLEN-1:0] ReadDataW;
  logic            MisalignW;

  modport master (
    output RegWriteM, MemWriteM, MemReadM, ResultSrcM, Funct3M, RD_M,
           PCPlus4M, WriteDataM, ALU_ResultM, FlushW,
    input  StallM, MisalignM, RegWriteW, ResultSrcW, RD_W, PCPlus4W,
           ALU_ResultW, ReadDataW, MisalignW
  );

  modport slave (
    input  RegWriteM, MemWriteM, MemReadM, ResultSrcM, Funct3M, RD_M,
           PCPlus4M, WriteDataM, ALU_ResultM, FlushW,
    output StallM, MisalignM, RegWriteW, ResultSrcW, RD_W, PCPlus4W,
           ALU_ResultW, ReadDataW, MisalignW
  );
endinterface

// File: rtl/mem_stage_ls.sv
// MEM stage with byte/half/word loads and stores, misalignment trap, wait-state
// FSM that stalls upstream, and the MEM/WB pipeline register.
module mem_stage_ls #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic           clk,
  input  logic           rst,
  mem_stage_ls_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  function automatic logic [XLEN-1:0] load_ext(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
    logic signed [7:0]      sb;
    logic signed [15:0]     sh;
    logic signed [31:0]     sw;
    logic signed [XLEN-1:0] r;
    sb = word[8*off +: 8];
    sh = off[1] ? word[31:16] : word[15:0];
    sw = word;
    case (f3)
      3'b000:  r = sb;
      3'b001:  r = sh;
      3'b010:  r = sw;
      3'b100:  r = XLEN'(sb[7:0]);
      3'b101:  r = XLEN'(sh[15:0]);
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [31:0]   mem_q [DEPTH_WORDS] = '{default: '0};

  logic [AW-1:0] widx;
  logic [1:0]    off;
  logic          is_half, is_word, valid, mis;
  logic [3:0]    be;
  logic [31:0]   wlanes;
  logic [31:0]   rword;
  logic          unused_addr;

  assign widx        = bus.ALU_ResultM[AW+1:2];
  assign off         = bus.ALU_ResultM[1:0];
  assign unused_addr = ^bus.ALU_ResultM[XLEN-1:AW+2];
  assign is_half     = (bus.Funct3M[1:0] == 2'b01);
  assign is_word     = (bus.Funct3M[1:0] == 2'b10);
  assign valid       = bus.MemReadM | bus.MemWriteM;
  assign mis         = valid & ((is_half & off[0]) | (is_word & (off != 2'b00)));
  assign rword       = mem_q[widx];
  assign bus.MisalignM = mis;

  always_comb begin
    be     = 4'b0000;
    wlanes = bus.WriteDataM[31:0];
    case (bus.Funct3M[1:0])
      2'b00: begin
        be     = 4'b0001 << off;
        wlanes = {4{bus.WriteDataM[7:0]}};
      end
      2'b01: begin
        be     = off[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{bus.WriteDataM[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Wait-state FSM: an aligned access holds StallM for WAIT_STATES cycles
  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       stall, done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if ((WAIT_STATES > 0) && valid && !mis) begin
          stall   = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end else begin
          done = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q != 3'd0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 3'd1;
        end else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gating with rst makes StallM fall the moment reset asserts
  assign bus.StallM = stall & rst;

  logic wr_en;
  assign wr_en = rst & done & bus.MemWriteM & ~mis;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[widx][8*b +: 8] <= wlanes[8*b +: 8];
      end
    end
  end

  // MEM/WB register boundary
  logic            regwrite_q, misalign_q;
  logic [1:0]      resultsrc_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] pcplus4_q, aluresult_q, readdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regwrite_q  <= 1'b0;
      resultsrc_q <= 2'b00;
      rd_q        <= 5'd0;
      pcplus4_q   <= '0;
      aluresult_q <= '0;
      readdata_q  <= '0;
      misalign_q  <= 1'b0;
    end else if (bus.FlushW || stall) begin
      regwrite_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      regwrite_q  <= bus.RegWriteM & ~mis;
      resultsrc_q <= bus.ResultSrcM;
      rd_q        <= bus.RD_M;
      pcplus4_q   <= bus.PCPlus4M;
      aluresult_q <= bus.ALU_ResultM;
      readdata_q  <= (bus.MemReadM && !mis) ? load_ext(rword, bus.Funct3M, off) : '0;
      misalign_q  <= mis;
    end
  end

  assign bus.RegWriteW   = regwrite_q;
  assign bus.ResultSrcW  = resultsrc_q;
  assign bus.RD_W        = rd_q;
  assign bus.PCPlus4W    = pcplus4_q;
  assign bus.ALU_ResultW = aluresult_q;
  assign bus.ReadDataW   = readdata_q;
  assign bus.MisalignW   = misalign_q;

endmodule

// File: tb/tb_mem_stage_ls.sv
// Directed bench for mem_stage_ls: one instance with no wait states and one with
// three, checked against hand-computed values.
module tb_mem_stage_ls;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic mis_seen, stall_seen;

  always #5 clk = ~clk;

  mem_stage_ls_if #(.XLEN(32)) if0 ();
  mem_stage_ls_if #(.XLEN(32)) if3 ();

  mem_stage_ls #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  mem_stage_ls #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .bus(if3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set0(input logic we, input logic re, input logic rw, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd);
    if0.MemWriteM   = we;
    if0.MemReadM    = re;
    if0.RegWriteM   = rw;
    if0.ResultSrcM  = re ? 2'b01 : 2'b00;
    if0.Funct3M     = f3;
    if0.RD_M        = 5'd9;
    if0.PCPlus4M    = addr + 32'd4;
    if0.ALU_ResultM = addr;
    if0.WriteDataM  = wd;
  endtask

  task automatic set3(input logic we, input logic re, input logic rw, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd);
    if3.MemWriteM   = we;
    if3.MemReadM    = re;
    if3.RegWriteM   = rw;
    if3.ResultSrcM  = re ? 2'b01 : 2'b00;
    if3.Funct3M     = f3;
    if3.RD_M        = 5'd9;
    if3.PCPlus4M    = addr + 32'd4;
    if3.ALU_ResultM = addr;
    if3.WriteDataM  = wd;
  endtask

  task automatic step0(input logic we, input logic re, input logic rw, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    set0(we, re, rw, f3, addr, wd);
    #1;
    mis_seen   = if0.MisalignM;
    stall_seen = if0.StallM;
    @(posedge clk);
    #1;
  endtask

  task automatic acc3(input logic we, input logic re, input logic rw, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd, input logic flush,
                      input string tag);
    @(negedge clk);
    set3(we, re, rw, f3, addr, wd);
    if3.FlushW = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 3) if3.FlushW = flush;
      #1;
      chk({tag, "_stall"}, {31'd0, if3.StallM}, (i < 3) ? 32'd1 : 32'd0);
      if (i > 0) chk({tag, "_rw_stall"}, {31'd0, if3.RegWriteW}, 32'd0);
      @(posedge clk);
    end
    #1;
    set3(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    if3.FlushW = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set0(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    set3(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    if0.FlushW = 1'b0;
    if3.FlushW = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_rw",    {31'd0, if0.RegWriteW}, 32'd0);
    chk("rst_src",   {30'd0, if0.ResultSrcW}, 32'd0);
    chk("rst_rd",    {27'd0, if0.RD_W}, 32'd0);
    chk("rst_pc",    if0.PCPlus4W, 32'd0);
    chk("rst_alu",   if0.ALU_ResultW, 32'd0);
    chk("rst_rdata", if0.ReadDataW, 32'd0);
    chk("rst_mis",   {31'd0, if0.MisalignW}, 32'd0);
    chk("rst_stall", {31'd0, if3.StallM}, 32'd0);
    @(negedge clk) rst = 1'b1;

    // No wait states
    step0(1'b1, 1'b0, 1'b0, 3'b010, 32'h10, 32'hDEADBEEF);
    chk("sw_stall", {31'd0, stall_seen}, 32'd0);
    chk("sw_misw",  {31'd0, if0.MisalignW}, 32'd0);
    step0(1'b0, 1'b1, 1'b1, 3'b010, 32'h10, 32'd0);
    chk("lw",     if0.ReadDataW, 32'hDEADBEEF);
    chk("lw_rw",  {31'd0, if0.RegWriteW}, 32'd1);
    chk("lw_src", {30'd0, if0.ResultSrcW}, 32'd1);
    chk("lw_rd",  {27'd0, if0.RD_W}, 32'd9);
    chk("lw_pc",  if0.PCPlus4W, 32'h14);
    step0(1'b0, 1'b1, 1'b1, 3'b000, 32'h13, 32'd0);
    chk("lb",  if0.ReadDataW, 32'hFFFFFFDE);
    step0(1'b0, 1'b1, 1'b1, 3'b100, 32'h13, 32'd0);
    chk("lbu", if0.ReadDataW, 32'h000000DE);
    step0(1'b0, 1'b1, 1'b1, 3'b001, 32'h12, 32'd0);
    chk("lh",  if0.ReadDataW, 32'hFFFFDEAD);
    step0(1'b0, 1'b1, 1'b1, 3'b101, 32'h10, 32'd0);
    chk("lhu", if0.ReadDataW, 32'h0000BEEF);

    step0(1'b1, 1'b0, 1'b0, 3'b000, 32'h11, 32'hFFFFFF55);
    step0(1'b1, 1'b0, 1'b0, 3'b001, 32'h12, 32'hABCD1234);
    step0(1'b0, 1'b1, 1'b1, 3'b010, 32'h10, 32'd0);
    chk("lw_partial", if0.ReadDataW, 32'h123455EF);

    step0(1'b0, 1'b1, 1'b1, 3'b010, 32'h12, 32'd0);
    chk("lw_mis_flag", {31'd0, mis_seen}, 32'd1);
    chk("lw_mis_w",    {31'd0, if0.MisalignW}, 32'd1);
    chk("lw_mis_rw",   {31'd0, if0.RegWriteW}, 32'd0);
    chk("lw_mis_data", if0.ReadDataW, 32'd0);

    step0(1'b1, 1'b0, 1'b0, 3'b001, 32'h21, 32'h0000FFFF);
    chk("sh_mis_w", {31'd0, if0.MisalignW}, 32'd1);
    step0(1'b0, 1'b1, 1'b1, 3'b010, 32'h20, 32'd0);
    chk("sh_mis_mem", if0.ReadDataW, 32'd0);
    chk("sh_mis_clr", {31'd0, if0.MisalignW}, 32'd0);

    step0(1'b0, 1'b0, 1'b1, 3'b000, 32'h10, 32'd0);
    chk("alu_rdata", if0.ReadDataW, 32'd0);
    chk("alu_res",   if0.ALU_ResultW, 32'h10);
    chk("alu_rw",    {31'd0, if0.RegWriteW}, 32'd1);

    step0(1'b1, 1'b0, 1'b0, 3'b010, 32'h1000, 32'hCAFEF00D);
    step0(1'b0, 1'b1, 1'b1, 3'b010, 32'h0000, 32'd0);
    chk("wrap", if0.ReadDataW, 32'hCAFEF00D);

    @(negedge clk);
    set0(1'b0, 1'b1, 1'b1, 3'b010, 32'h10, 32'd0);
    if0.FlushW = 1'b1;
    @(posedge clk);
    #1;
    chk("flush0_rw",   {31'd0, if0.RegWriteW}, 32'd0);
    chk("flush0_hold", if0.ReadDataW, 32'hCAFEF00D);
    chk("flush0_alu",  if0.ALU_ResultW, 32'h0);
    if0.FlushW = 1'b0;
    set0(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);

    // Three wait states
    acc3(1'b1, 1'b0, 1'b0, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, "sw3");
    acc3(1'b0, 1'b1, 1'b1, 3'b010, 32'h10, 32'd0, 1'b0, "lw3");
    chk("lw3_data", if3.ReadDataW, 32'hDEADBEEF);
    chk("lw3_rw",   {31'd0, if3.RegWriteW}, 32'd1);
    acc3(1'b0, 1'b1, 1'b1, 3'b010, 32'h10, 32'd0, 1'b1, "lwf3");
    chk("lwf3_rw", {31'd0, if3.RegWriteW}, 32'd0);

    @(negedge clk);
    set3(1'b0, 1'b1, 1'b1, 3'b010, 32'h12, 32'd0);
    #1;
    chk("mis3_stall", {31'd0, if3.StallM}, 32'd0);
    chk("mis3_flag",  {31'd0, if3.MisalignM}, 32'd1);
    @(posedge clk);
    #1;
    chk("mis3_w",     {31'd0, if3.MisalignW}, 32'd1);
    chk("mis3_idle",  {31'd0, if3.StallM}, 32'd0);
    set3(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);

    acc3(1'b1, 1'b0, 1'b0, 3'b010, 32'h40, 32'h11112222, 1'b0, "sw40");

    @(negedge clk);
    set3(1'b1, 1'b0, 1'b0, 3'b010, 32'h40, 32'hAAAA5555);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rmid_stall", {31'd0, if3.StallM}, 32'd0);
    chk("rmid_rw",    {31'd0, if3.RegWriteW}, 32'd0);
    chk("rmid_src",   {30'd0, if3.ResultSrcW}, 32'd0);
    chk("rmid_rd",    {27'd0, if3.RD_W}, 32'd0);
    chk("rmid_pc",    if3.PCPlus4W, 32'd0);
    chk("rmid_alu",   if3.ALU_ResultW, 32'd0);
    chk("rmid_rdata", if3.ReadDataW, 32'd0);
    chk("rmid_mis",   {31'd0, if3.MisalignW}, 32'd0);
    set3(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    @(negedge clk);
    @(negedge clk) rst = 1'b1;

    acc3(1'b0, 1'b1, 1'b1, 3'b010, 32'h40, 32'd0, 1'b0, "lw40");
    chk("lw40_old", if3.ReadDataW, 32'h11112222);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_ls.md
# mem_stage_ls

Parametrised MEM stage of the 5-stage RISC-V pipeline, with the MEM/WB pipeline register. It adds byte/halfword loads and stores with sign/zero extension, misalignment detection, a configurable wait-state FSM that stalls upstream stages, and a WB-side flush. It sits between the EX/MEM register and the writeback mux and is a drop-in for the word-only memory stage.

## Interface

Parameters:
- XLEN, default 32: data and address width.
- DEPTH_WORDS, default 1024: data memory depth in words. Must be a power of two.
- WAIT_STATES, default 0: extra cycles per memory access. Legal range 0..7.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- RegWriteM, MemWriteM, MemReadM  in  1 each  control signals from EX/MEM.
- ResultSrcM  in  2  writeback select: 00 ALU, 01 memory, 10 PC+4. Passed through.
- Funct3M  in  3  access size/sign. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- RD_M  in  5  destination register.
- PCPlus4M, WriteDataM, ALU_ResultM  in  XLEN each  ALU_ResultM is the byte address.
- FlushW  in  1  loads a bubble into MEM/WB at the next edge.
- StallM  out  1  access in progress; upstream must hold all M inputs stable.
- MisalignM  out  1  combinational misalignment flag for the current access.
- RegWriteW, ResultSrcW[1:0], RD_W[4:0], PCPlus4W, ALU_ResultW, ReadDataW, MisalignW  out  MEM/WB register outputs.

## Operation

Addressing:
- Word index = ALU_ResultM[log2(DEPTH_WORDS)+1:2].
- Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Memory array is zero at time 0. Reset does not clear it.

Stores:
- SB writes the byte lane selected by addr[1:0] with WriteDataM[7:0].
- SH writes lanes {addr[1],0} and {addr[1],1} with WriteDataM[15:0].
- SW writes all four lanes.
- Lanes that are not enabled keep their value.

Loads:
- The selected byte or halfword is right-aligned.
- LB and LH sign-extend to XLEN; LBU and LHU zero-extend; LW returns the word as-is.
- Non-access instructions register ReadDataW = 0.

Misalignment:
- MisalignM = (MemReadM|MemWriteM) & ((half & addr[0]) | (word & addr[1:0]!=0)).
- A misaligned store is suppressed, and memory is unchanged.
- A misaligned load registers ReadDataW = 0.
- Either case registers MisalignW = 1 and forces RegWriteW = 0.
- A misaligned access never enters BUSY.

FSM (IDLE, BUSY) with a 3-bit counter cnt:
- IDLE, valid aligned access, WAIT_STATES>0: StallM=1, cnt <= WAIT_STATES-1, go to BUSY.
- IDLE, otherwise: StallM=0 and the access completes this cycle.
- BUSY, cnt!=0: StallM=1, cnt <= cnt-1.
- BUSY, cnt==0: StallM=0, the access completes, go to IDLE.
- With WAIT_STATES=0 the FSM stays in IDLE.

Completion:
- The store is committed on the completing edge.
- Load data is sampled from the array on that edge.
- The MEM/WB register captures all fields on that edge.

MEM/WB register priority at each edge:
- Reset first.
- Then FlushW: bubble.
- Then StallM=1: bubble.
- Otherwise, capture.

A bubble sets RegWriteW=0 and MisalignW=0; the other W fields hold. FlushW does not affect the FSM or pending memory writes.

## Timing

- Reset values: RegWriteW=0, ResultSrcW=00, RD_W=0, PCPlus4W=0, ALU_ResultW=0, ReadDataW=0, MisalignW=0, StallM=0, FSM=IDLE, cnt=0.
- Latency: an access presented at edge N appears on the W outputs after edge N+1+WAIT_STATES.
- StallM is high for exactly WAIT_STATES cycles per aligned access and low on the completing cycle.
- Back-to-back accesses: the cycle after completion is IDLE, so the next access starts immediately. There is no dead cycle.
- Reset mid-BUSY:
  - FSM returns to IDLE and StallM drops asynchronously.
  - The pending store is dropped and memory is untouched.
  - All W outputs are cleared.
- A load to an address written by the immediately preceding store sees the new data, because the write commits before the load's completing edge.

## Test plan

- SW 0xDEADBEEF @0x10, then loads @0x10..0x13:
  - LW @0x10 -> ReadDataW=0xDEADBEEF.
  - LB @0x13 -> 0xFFFFFFDE.
  - LBU @0x13 -> 0x000000DE.
  - LH @0x12 -> 0xFFFFDEAD.
  - LHU @0x10 -> 0x0000BEEF.
- Partial store: after the SW above, SB 0x55 @0x11 and SH 0x1234 @0x12, then LW @0x10 -> 0x123455EF.
- Misalignment:
  - LW @0x12 -> MisalignW=1, RegWriteW=0, ReadDataW=0.
  - SH 0xFFFF @0x21 -> MisalignW=1; a following LW @0x20 returns the prior contents (0).
- Wait states, WAIT_STATES=3, LW @0x10:
  - StallM is high 3 cycles and W updates on the 4th edge.
  - RegWriteW=0 during the stall cycles.
  - FlushW pulsed in the completing cycle gives RegWriteW=0.
- Reset mid-access, WAIT_STATES=3:
  - Assert rst during the 2nd stall cycle of a SW 0xAAAA5555 @0x40.
  - Required: all W outputs 0 and StallM 0 immediately; LW @0x40 after release returns the old value.
- Wrap with DEPTH_WORDS=1024: SW 0xCAFEF00D @0x1000, then LW @0x0000 -> 0xCAFEF00D.
